// File: rtl/math_result_buffer.sv
// math_result_buffer: FWFT FIFO that captures math_expression results and presents them over valid/ready.
// Tracks issued-but-not-captured results so the issuer only starts an operation that has a guaranteed slot.
module math_result_buffer #(
    parameter int W = 32,
    parameter int DEPTH = 8,
    localparam int QW = 2*W+4,
    localparam int CW = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [QW-1:0] in_q,
    input  logic          in_rmd,
    input  logic          issue,
    output logic          can_issue,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_q,
    output logic          out_rmd,
    output logic [CW-1:0] count,
    output logic [CW-1:0] inflight,
    output logic          overflow,
    output logic          credit_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = CW + 1;

    logic [QW:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, inflight_q, inflight_d;
    logic          overflow_q, overflow_d, credit_err_q, credit_err_d;
    logic          push, pop;

    always_comb begin
        out_valid    = count_q != '0;
        out_q        = out_valid ? mem_q[rd_ptr_q][QW:1] : '0;
        out_rmd      = out_valid ? mem_q[rd_ptr_q][0] : 1'b0;
        can_issue    = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);
        pop          = out_valid & out_ready;
        push         = in_valid & ((count_q < CW'(DEPTH)) | pop);
        count_d      = count_q + CW'(push) - CW'(pop);
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        // Saturate at both ends so a misbehaving issuer cannot wrap the counter.
        inflight_d   = (issue & ~in_valid) ? ((&inflight_q) ? inflight_q : inflight_q + CW'(1)) :
                       (in_valid & ~issue & (inflight_q != '0)) ? inflight_q - CW'(1) : inflight_q;
        overflow_d   = overflow_q | (in_valid & ~push);
        credit_err_d = credit_err_q | (issue & ~can_issue) | (in_valid & (inflight_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            overflow_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            overflow_q   <= overflow_d;
            credit_err_q <= credit_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_q, in_rmd};
    end

    assign count      = count_q;
    assign inflight   = inflight_q;
    assign overflow   = overflow_q;
    assign credit_err = credit_err_q;
endmodule

// File: tb/tb_math_result_buffer.sv
// tb_math_result_buffer: directed stimulus with a queue scoreboard checking popped results.
module tb_math_result_buffer;
    localparam int W = 8;
    localparam int DEPTH = 8;
    localparam int QW = 2*W+4;
    localparam int CW = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [QW-1:0] in_q = '0;
    logic          in_rmd = 1'b0;
    logic          issue = 1'b0;
    logic          can_issue;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [QW-1:0] out_q;
    logic          out_rmd;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          overflow;
    logic          credit_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [QW:0] exp_q [$];

    math_result_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_q(in_q), .in_rmd(in_rmd),
        .issue(issue), .can_issue(can_issue), .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_rmd(out_rmd), .count(count), .inflight(inflight),
        .overflow(overflow), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic send(input logic [QW-1:0] q, input logic r);
        in_valid = 1'b1;
        in_q = q;
        in_rmd = r;
        exp_q.push_back({q, r});
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: every accepted head must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got %0h expected none", {out_q, out_rmd});
            end else begin
                if ({out_q, out_rmd} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL pop_data: got %0h expected %0h", {out_q, out_rmd}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_idle(input string nm);
        chk({nm, "_count"}, 32'(count), 0);
        chk({nm, "_inflight"}, 32'(inflight), 0);
        chk({nm, "_out_valid"}, 32'(out_valid), 0);
        chk({nm, "_out_q"}, 32'(out_q), 0);
        chk({nm, "_overflow"}, 32'(overflow), 0);
        chk({nm, "_credit_err"}, 32'(credit_err), 0);
        chk({nm, "_can_issue"}, 32'(can_issue), 1);
    endtask

    initial begin
        int n_iss;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_idle("reset");

        // Single round trip: numerator 8 -> q=4, rmd=0
        issue = 1'b1;
        step();
        issue = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rt_inflight", 32'(inflight), 1);
            chk("rt_no_valid", 32'(out_valid), 0);
            if (i < 3) step();
        end
        send(20'd4, 1'b0);
        chk("rt_valid", 32'(out_valid), 1);
        chk("rt_count", 32'(count), 1);
        chk("rt_inflight0", 32'(inflight), 0);
        chk("rt_out_q", 32'(out_q), 4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rt_drained", 32'(out_valid), 0);

        // Three back-to-back results, popped in order
        for (int i = 0; i < 3; i++) begin
            issue = 1'b1;
            step();
        end
        issue = 1'b0;
        send(20'd1, 1'b1);
        send(20'hFFFFE, 1'b0);
        send(20'd4, 1'b0);
        chk("b2b_count", 32'(count), 3);
        chk("b2b_head", 32'(out_q), 1);
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        chk("b2b_empty", 32'(out_valid), 0);
        chk("b2b_count0", 32'(count), 0);

        // Issue while credit is available: exactly DEPTH accepted
        n_iss = 0;
        for (int i = 0; i < 12; i++) begin
            issue = can_issue;
            if (can_issue) n_iss++;
            step();
        end
        issue = 1'b0;
        chk("fill_issues", 32'(n_iss), 8);
        chk("fill_inflight", 32'(inflight), 8);
        chk("fill_can_issue", 32'(can_issue), 0);
        for (int i = 0; i < 8; i++) send(20'(100 + i), i[0]);
        chk("fill_count", 32'(count), 8);
        chk("fill_can_issue_full", 32'(can_issue), 0);
        chk("fill_overflow", 32'(overflow), 0);
        chk("fill_credit_err", 32'(credit_err), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_frees_credit", 32'(can_issue), 1);
        chk("pop_count", 32'(count), 7);
        issue = 1'b1;
        step();
        issue = 1'b0;
        send(20'd108, 1'b0);
        chk("refill_count", 32'(count), 8);

        // Issue without credit is counted and flagged
        issue = 1'b1;
        step();
        issue = 1'b0;
        chk("noc_credit_err", 32'(credit_err), 1);
        chk("noc_inflight", 32'(inflight), 1);

        // Full with simultaneous pop: push accepted
        out_ready = 1'b1;
        send(20'd200, 1'b1);
        out_ready = 1'b0;
        chk("fullpop_count", 32'(count), 8);
        chk("fullpop_overflow", 32'(overflow), 0);
        chk("sticky_credit_err", 32'(credit_err), 1);

        // Full without pop: dropped, never enqueued in the scoreboard
        in_valid = 1'b1;
        in_q = 20'h3E7;
        in_rmd = 1'b1;
        step();
        in_valid = 1'b0;
        chk("drop_overflow", 32'(overflow), 1);
        chk("drop_count", 32'(count), 8);
        chk("drop_inflight_floor", 32'(inflight), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_out_q", 32'(out_q), 0);
        chk("overflow_sticky", 32'(overflow), 1);

        // Unsolicited result: flagged yet stored
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        chk("reset2_credit_err", 32'(credit_err), 0);
        send(20'd7, 1'b1);
        chk("unsol_credit_err", 32'(credit_err), 1);
        chk("unsol_count", 32'(count), 1);
        chk("unsol_out_q", 32'(out_q), 7);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-operation with count=5, inflight=2
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            issue = 1'b1;
            step();
        end
        issue = 1'b0;
        for (int i = 0; i < 5; i++) send(20'(300 + i), 1'b0);
        chk("mid_count", 32'(count), 5);
        chk("mid_inflight", 32'(inflight), 2);
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        check_idle("midreset");
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/math_result_buffer.md
Name: math_result_buffer

Overview:
Downstream stage of the math_expression pipeline. math_expression emits a one-cycle q/rmd result pulse and cannot be stalled. This block captures every result into a FIFO and presents it to the consumer over a valid/ready interface. It also runs credit accounting so the issuing logic asserts math_expression start only when a FIFO slot is guaranteed for that result.

Parameters:
W, 32, operand width of math_expression; result width QW = 2*W+4 (localparam, not overridable)
DEPTH, 8, FIFO entries; power of 2, >= 2
CW, clog2(DEPTH+1), width of the occupancy and in-flight counters (localparam)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
in_valid  in  1  result pulse from math_expression valid
in_q  in  QW  signed quotient from math_expression q
in_rmd  in  1  remainder bit from math_expression rmd
issue  in  1  high in any cycle math_expression start is driven high
can_issue  out  1  high when one more issue is safe
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_q  out  QW  head quotient
out_rmd  out  1  head remainder
count  out  CW  entries stored
inflight  out  CW  issued results not yet captured
overflow  out  1  sticky: result dropped on a full FIFO
credit_err  out  1  sticky: issue without credit, or in_valid with inflight==0

Behaviour:
- Reset (synchronous, active-high): pointers, count, inflight, overflow and credit_err all go to 0. out_valid=0, out_q=0, out_rmd=0 in the cycle after the reset edge. Reset mid-operation discards stored entries. math_expression shares this reset, so no stale pulses arrive afterwards.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0).
  - out_q/out_rmd come combinationally from the entry at rd_ptr, forced to 0 when empty.
- pop = out_valid & out_ready. Advances rd_ptr on the clock edge. out_ready while empty has no effect.
- push = in_valid & (count < DEPTH | pop). Writes {in_q,in_rmd} at wr_ptr, then advances wr_ptr.
  - Full with simultaneous pop: the push is accepted and count stays DEPTH.
  - Empty with in_valid: the data appears on out_q the next cycle. There is no same-cycle bypass.
- in_valid while full and no pop: data dropped, count unchanged, overflow set and held until reset.
- Pointers wrap modulo DEPTH. count = push - pop net change each cycle; pushes and pops in the same cycle leave it unchanged.
- Latency: in_valid at edge N gives out_valid high after edge N. Round trip is issue at cycle 0, in_valid at cycle 4 (math_expression latency), out_valid at cycle 5.
- Credit accounting:
  - inflight increments on issue and decrements on in_valid. Both in one cycle leaves it unchanged.
  - inflight saturates at 2^CW-1 and never drops below 0.
  - in_valid with inflight==0 sets credit_err, and the data is still pushed.
- can_issue = (count + inflight) < DEPTH, computed from registered values, so it is combinational-free of issue and in_valid.
  - Pops free credit one cycle later.
  - issue while can_issue==0 is still counted and sets credit_err.
- Width rule: in_q is stored bit-exact with no sign manipulation. Consumer reconstructs numerator = 2*q + rmd.
- No state machine beyond pointers and counters. Implementation target is about 150-250 lines.

Test Plan:
- W=8. Reset, then issue with a=5,b=2,c=1,d=1 (numerator 8) -> inflight=1 for 4 cycles, then out_valid with out_q=4, out_rmd=0; count=1; inflight=0.
- Three back-to-back results: (a=3,b=c=d=0)->q=1,rmd=1; (a=0,b=1,c=1,d=0)->q=-2,rmd=0; (a=5,b=2,c=1,d=1)->q=4. out_ready=0 -> count=3. Then out_ready=1 -> popped in order 1, -2, 4 on consecutive cycles, then out_valid=0.
- DEPTH=8, out_ready=0, issue every cycle while can_issue -> exactly 8 issues accepted. can_issue drops when count+inflight=8, with no overflow and no credit_err. A single pop raises can_issue the next cycle.
- FIFO full, in_valid and out_ready in the same cycle -> push accepted, count stays 8, overflow=0. Repeat with out_ready=0 -> overflow=1, count=8, the dropped value never appears.
- Force issue while can_issue=0 -> credit_err=1 and sticky; separately, in_valid with inflight=0 -> credit_err=1 and data still stored.
- Reset asserted with count=5, inflight=2 -> next cycle count=0, inflight=0, out_valid=0, out_q=0, flags cleared, can_issue=1.
